// File: rtl/sa_pkg.sv
// Shared types and defaults for the systolic tile result writer.
package sa_pkg;

    localparam int unsigned N_DEFAULT  = 8;
    localparam int unsigned AW_DEFAULT = 12;

    // One quantized tile row; element 0 is column 0.
    typedef logic [N_DEFAULT-1:0][7:0] row_t;

    // Write-side payload as buffered in the FIFO.
    typedef struct packed {
        logic [AW_DEFAULT-1:0] addr;
        row_t                  data;
    } wr_beat_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } wr_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Pointer/count synchronous FIFO with a registered head and registered flags.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr_inc;
    logic             do_push;
    logic             do_pop;
    logic [PW:0]      count_nxt;
    logic [WIDTH-1:0] head_nxt;

    // Handshake qualification, next occupancy and next head word.
    always_comb begin
        do_pop     = pop && !empty;
        do_push    = push && (!full || do_pop);
        rd_ptr_inc = rd_ptr + PW'(1);
        count_nxt  = count;
        if (do_push && !do_pop) begin
            count_nxt = count + (PW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - (PW+1)'(1);
        end
        head_nxt = dout;
        if (count_nxt != '0) begin
            if (do_pop) begin
                head_nxt = (count == (PW+1)'(1)) ? din : mem[rd_ptr_inc];
            end else if (empty && do_push) begin
                head_nxt = din;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            dout   <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == (PW+1)'(DEPTH));
            dout  <= head_nxt;
        end
    end

endmodule

// File: rtl/sa_result_writer.sv
// Addresses tile-row beats from the systolic array and writes them to the output SRAM.
module sa_result_writer
    import sa_pkg::*;
#(
    parameter int unsigned N          = N_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AW         = AW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          row_shape,
    input  logic [7:0]          col_shape,
    input  logic                in_wen_n,
    input  logic [AW-1:0]       in_waddr,
    input  logic [N-1:0][7:0]   in_data,
    output logic                mem_req,
    input  logic                mem_gnt,
    output logic                mem_wen_n,
    output logic [AW-1:0]       mem_waddr,
    output logic [N*8-1:0]      mem_wdata,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int unsigned WORD_W = N * 8;
    localparam int unsigned BEAT_W = AW + WORD_W;
    localparam int unsigned BCW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW     = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         state;
    wr_state_e         state_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    logic [7:0]        rs_q;
    logic [7:0]        cs_q;
    logic [BCW-1:0]    beat_cnt;
    logic [7:0]        tile_col;
    logic [7:0]        tile_row;

    logic              accept;
    logic              pop;
    logic              last_beat;
    logic              zero_shape;
    logic [31:0]       addr_full;

    logic [BEAT_W-1:0] fifo_din;
    logic [BEAT_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;

    // The array-side address is informational only.
    logic              unused_waddr;
    assign unused_waddr = ^in_waddr;

    // Beat acceptance, transfer detection and row-major address of the current beat.
    always_comb begin
        accept     = (state == RUN) && !in_wen_n && !start;
        pop        = mem_req && mem_gnt;
        zero_shape = (row_shape == 8'd0) || (col_shape == 8'd0);
        last_beat  = (beat_cnt == BCW'(N - 1)) &&
                     (tile_col == cs_q - 8'd1) &&
                     (tile_row == rs_q - 8'd1);
        addr_full  = (32'(tile_row) * 32'(N) + 32'(beat_cnt)) * 32'(cs_q) + 32'(tile_col);
        fifo_din   = {AW'(addr_full), in_data};
    end

    sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .push  (accept),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign mem_req   = !fifo_empty;
    assign mem_wen_n = !(mem_req && mem_gnt);
    assign mem_waddr = fifo_dout[BEAT_W-1 -: AW];
    assign mem_wdata = fifo_dout[WORD_W-1:0];

    // Job sequencing: next state plus busy/done for the following cycle.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = zero_shape ? FIN : RUN;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                RUN:     if (accept && last_beat) state_nxt = DRAIN;
                DRAIN:   if (fifo_empty || (pop && fifo_count == CW'(1))) state_nxt = FIN;
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == FIN);
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // Tile/beat counters (beat innermost, then column, then row) and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_q     <= '0;
            cs_q     <= '0;
            beat_cnt <= '0;
            tile_col <= '0;
            tile_row <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            rs_q     <= row_shape;
            cs_q     <= col_shape;
            beat_cnt <= '0;
            tile_col <= '0;
            tile_row <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            if (fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (beat_cnt == BCW'(N - 1)) begin
                beat_cnt <= '0;
                if (tile_col == cs_q - 8'd1) begin
                    tile_col <= '0;
                    tile_row <= (tile_row == rs_q - 8'd1) ? 8'd0 : tile_row + 8'd1;
                end else begin
                    tile_col <= tile_col + 8'd1;
                end
            end else begin
                beat_cnt <= beat_cnt + BCW'(1);
            end
        end
    end

endmodule

// File: doc/sa_result_writer.md
Name: sa_result_writer

Overview:
- Downstream stage of the shift-fed NxN systolic tile engine.
- Each output beat carries one quantized tile row of N int8 values. The block assigns every beat a global row-major address in the output SRAM and buffers it in a small FIFO.
- Writes are issued to a shared output-SRAM port under a req/gnt handshake.
- Tracks tile progress over row_shape x col_shape tiles and reports completion after the last word is committed.

Parameters:
- N, 8, tile edge; one output word = N bytes.
- FIFO_DEPTH, 4, buffered beats; power of two, >= 2.
- AW, 12, output SRAM address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a job and clears all counters
- row_shape  in  8  tile rows; N*row_shape = matrix rows
- col_shape  in  8  tile cols; N*col_shape = matrix cols
- in_wen_n  in  1  active-low beat strobe from the array
- in_waddr  in  AW  array-side row address; informational only, ignored
- in_data  in  N x 8  quantized row, element 0 = column 0
- mem_req  out  1  write request to the output SRAM port
- mem_gnt  in  1  port grant; a transfer occurs when mem_req && mem_gnt
- mem_wen_n  out  1  active-low write strobe = !(mem_req && mem_gnt)
- mem_waddr  out  AW  write word address
- mem_wdata  out  N*8  write data, element i at bits [8i+7:8i]
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the final write transfers
- overflow  out  1  sticky: a beat was dropped because the FIFO was full

Behaviour:
- Reset values: mem_req=0, mem_wen_n=1, mem_waddr=0, mem_wdata=0, busy=0, done=0, overflow=0; FIFO empty; FSM in IDLE.
- FSM states:
  - IDLE: on start go to RUN. If row_shape==0 or col_shape==0, go to FIN instead.
  - RUN: accept beats. After the final beat is accepted, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and no transfer is pending, then go to FIN.
  - FIN: done=1 for one cycle, then IDLE.
- start in any non-IDLE state restarts the job:
  - FIFO flushed, counters zeroed, overflow cleared.
  - Enter RUN, or FIN if a shape is 0.
- Counters:
  - beat_cnt runs 0..N-1.
  - tile_col runs 0..col_shape-1, innermost.
  - tile_row runs 0..row_shape-1.
  - This order matches the array's tile order: column advances first.
- A beat is accepted only in RUN when in_wen_n==0. Beats in other states are ignored.
- Address per beat: ((tile_row*N + beat_cnt)*col_shape + tile_col). Compute at full width, then truncate to AW bits; it wraps modulo 2^AW.
- Counters advance on every accepted beat, even a dropped one. Addressing therefore stays aligned after an overflow.
- FIFO operation:
  - Push on an accepted beat. Pop on mem_req && mem_gnt.
  - mem_req = FIFO non-empty. mem_waddr and mem_wdata are the FIFO head, registered outputs.
  - Latency: a beat in cycle t gives earliest mem_req in cycle t+1.
  - Full, push and pop in the same cycle: the push is accepted and no overflow occurs.
  - Full and push without pop: the beat is dropped and overflow is set.
  - mem_req may be held for any number of cycles without grant. Head address and data stay stable while mem_req=1 && !mem_gnt.
- Total beats per job = row_shape*col_shape*N. The last beat has tile_row=row_shape-1, tile_col=col_shape-1, beat_cnt=N-1.
- done fires in FIN, the cycle after the last pop, or the cycle after start for a zero shape. busy falls together with done.
- Reset mid-job: immediate return to the reset state; no further mem_req.

Decomposition:
- Package sa_pkg:
  - N_DEFAULT and AW_DEFAULT.
  - typedef row_t = logic [N-1:0][7:0].
  - typedef struct wr_beat_t {addr, data}.
  - enum wr_state_e {IDLE, RUN, DRAIN, FIN}.
- One sub-module: sync_fifo (parameterised width/depth).
  - Ports: push, pop, din, dout, full, empty.
  - Pointer-based with a count; simultaneous push/pop at full is legal.

Test Plan:
- row_shape=1, col_shape=1, mem_gnt tied 1, 8 consecutive beats with rows of value r:
  - -> 8 writes to addr 0..7 with data = row r.
  - -> done exactly 1 cycle after the 8th write; overflow=0.
- row_shape=2, col_shape=3, gnt=1, 48 beats:
  - -> the first beat of tile (1,2) writes addr (8*1+0)*3+2=26; the last beat writes addr 47.
  - -> all 48 addresses written exactly once.
- gnt=0 for 3 cycles while 3 beats arrive, then gnt=1:
  - -> the head addr/data are held stable during the stall.
  - -> writes occur in order with no loss; overflow=0.
- gnt=0 with 5 beats into FIFO_DEPTH=4:
  - -> overflow=1 after the 5th beat; only 4 writes occur once gnt=1.
  - -> done still pulses; the dropped beat's address is never written.
- col_shape=0 start -> done at start+1; no mem_req; busy pulses for one cycle.
- rst_n low during DRAIN, or start re-issued in RUN:
  - -> mem_req=0 the next cycle, FIFO empty, counters 0, overflow cleared.
  - -> a subsequent job's addressing restarts at 0.
